// File: rtl/axi4l_master_ipif.sv
// Simple user-side register port bridged to an AXI4-Lite master.
// Write and read paths run as independent FSMs; acks pulse the cycle after the response handshake.
module axi4l_master_ipif #(
  parameter int C_ADDR_WIDTH = 12,
  parameter int C_DATA_WIDTH = 32
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [C_ADDR_WIDTH-3:0] wr_addr,
  input  logic                    wr_req,
  input  logic [3:0]              wr_be,
  input  logic [C_DATA_WIDTH-1:0] wr_data,
  output logic                    wr_ack,
  output logic                    wr_err,
  output logic                    wr_busy,
  input  logic [C_ADDR_WIDTH-3:0] rd_addr,
  input  logic                    rd_req,
  output logic [C_DATA_WIDTH-1:0] rd_data,
  output logic                    rd_ack,
  output logic                    rd_err,
  output logic                    rd_busy,
  output logic [31:0]             m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [C_DATA_WIDTH-1:0] m_axi_wdata,
  output logic [3:0]              m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [31:0]             m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [C_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);
  localparam int AW = C_ADDR_WIDTH - 2;

  generate
    if (C_DATA_WIDTH != 32) begin : g_bad_width
      $error("axi4l_master_ipif: C_DATA_WIDTH must be 32");
    end
  endgenerate

  typedef enum logic [2:0] {W_IDLE, W_BOTH, W_AONLY, W_DONLY, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_e;

  wstate_e                 w_q, w_d;
  rstate_e                 r_q, r_d;
  logic [AW-1:0]           awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [C_DATA_WIDTH-1:0] wdata_q, wdata_d, rd_data_q, rd_data_d;
  logic [3:0]              wstrb_q, wstrb_d;
  logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic                    wr_ack_q, wr_ack_d, wr_err_q, wr_err_d;
  logic                    rd_ack_q, rd_ack_d, rd_err_q, rd_err_d;
  logic                    aw_hs, w_hs;

  assign aw_hs = awvalid_q & m_axi_awready;
  assign w_hs  = wvalid_q & m_axi_wready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_q       <= W_IDLE;
      r_q       <= R_IDLE;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rd_data_q <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wr_ack_q  <= 1'b0;
      wr_err_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
      rd_err_q  <= 1'b0;
    end else begin
      w_q       <= w_d;
      r_q       <= r_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rd_data_q <= rd_data_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      wr_ack_q  <= wr_ack_d;
      wr_err_q  <= wr_err_d;
      rd_ack_q  <= rd_ack_d;
      rd_err_q  <= rd_err_d;
    end
  end

  // Write path: AW and W complete in either order; states name what is still pending.
  always_comb begin
    w_d      = w_q;
    awaddr_d = awaddr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    wr_ack_d = 1'b0;
    wr_err_d = 1'b0;
    case (w_q)
      W_IDLE: if (wr_req) begin
        w_d      = W_BOTH;
        awaddr_d = wr_addr;
        wdata_d  = wr_data;
        wstrb_d  = wr_be;
      end
      W_BOTH: begin
        if (aw_hs && w_hs) w_d = W_RESP;
        else if (aw_hs)    w_d = W_DONLY;
        else if (w_hs)     w_d = W_AONLY;
      end
      W_AONLY: if (aw_hs) w_d = W_RESP;
      W_DONLY: if (w_hs)  w_d = W_RESP;
      W_RESP: if (m_axi_bvalid) begin
        w_d      = W_IDLE;
        wr_ack_d = 1'b1;
        wr_err_d = m_axi_bresp[1];
      end
      default: w_d = W_IDLE;
    endcase
    awvalid_d = (w_d == W_BOTH) || (w_d == W_AONLY);
    wvalid_d  = (w_d == W_BOTH) || (w_d == W_DONLY);
  end

  always_comb begin
    r_d       = r_q;
    araddr_d  = araddr_q;
    rd_data_d = rd_data_q;
    rd_ack_d  = 1'b0;
    rd_err_d  = 1'b0;
    case (r_q)
      R_IDLE: if (rd_req) begin
        r_d      = R_ADDR;
        araddr_d = rd_addr;
      end
      R_ADDR: if (m_axi_arready) r_d = R_DATA;
      R_DATA: if (m_axi_rvalid) begin
        r_d       = R_IDLE;
        rd_data_d = m_axi_rdata;
        rd_ack_d  = 1'b1;
        rd_err_d  = m_axi_rresp[1];
      end
      default: r_d = R_IDLE;
    endcase
  end

  assign m_axi_awaddr  = 32'({awaddr_q, 2'b00});
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = (w_q == W_RESP);
  assign m_axi_araddr  = 32'({araddr_q, 2'b00});
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = (r_q == R_ADDR);
  assign m_axi_rready  = (r_q == R_DATA);

  assign wr_ack  = wr_ack_q;
  assign wr_err  = wr_err_q;
  assign wr_busy = (w_q != W_IDLE);
  assign rd_data = rd_data_q;
  assign rd_ack  = rd_ack_q;
  assign rd_err  = rd_err_q;
  assign rd_busy = (r_q != R_IDLE);
endmodule

// File: tb/tb_axi4l_master_ipif.sv
// Directed bench for axi4l_master_ipif with a small reactive AXI4-Lite slave.
module tb_axi4l_master_ipif;
  logic        aclk = 1'b0;
  logic        areset;
  logic [9:0]  wr_addr, rd_addr;
  logic        wr_req, rd_req;
  logic [3:0]  wr_be;
  logic [31:0] wr_data, rd_data;
  logic        wr_ack, wr_err, wr_busy, rd_ack, rd_err, rd_busy;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  logic [1:0]  bresp_cfg, rresp_cfg;
  logic [31:0] rdata_cfg;
  logic        b_hold;
  int          rwait_cfg;
  logic        aw_got, w_got, r_pend;
  int          r_cnt;
  int          aw_cnt = 0, wr_ack_cnt = 0, rd_ack_cnt = 0;
  logic [31:0] aw_seen, w_seen;
  int          n_chk = 0, n_err = 0;

  always #5 aclk = ~aclk;

  axi4l_master_ipif dut (
    .aclk(aclk), .areset(areset),
    .wr_addr(wr_addr), .wr_req(wr_req), .wr_be(wr_be), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_err(wr_err), .wr_busy(wr_busy),
    .rd_addr(rd_addr), .rd_req(rd_req), .rd_data(rd_data),
    .rd_ack(rd_ack), .rd_err(rd_err), .rd_busy(rd_busy),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  assign m_axi_bresp = bresp_cfg;
  assign m_axi_rresp = rresp_cfg;
  assign m_axi_rdata = rdata_cfg;

  // Slave: B follows once both AW and W have handshaken; R follows AR after rwait_cfg cycles.
  always @(posedge aclk or posedge areset) begin
    logic a_ok, d_ok;
    if (areset) begin
      m_axi_bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
      m_axi_rvalid <= 1'b0; r_pend <= 1'b0; r_cnt <= 0;
    end else begin
      a_ok = aw_got || (m_axi_awvalid && m_axi_awready);
      d_ok = w_got || (m_axi_wvalid && m_axi_wready);
      if (a_ok && d_ok && !b_hold && !m_axi_bvalid) begin
        m_axi_bvalid <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        aw_got <= a_ok; w_got <= d_ok;
      end
      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
      if (m_axi_arvalid && m_axi_arready) begin
        if (rwait_cfg == 0) m_axi_rvalid <= 1'b1;
        else begin r_pend <= 1'b1; r_cnt <= rwait_cfg - 1; end
      end else if (r_pend) begin
        if (r_cnt == 0) begin m_axi_rvalid <= 1'b1; r_pend <= 1'b0; end
        else r_cnt <= r_cnt - 1;
      end
      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
    end
  end

  always @(posedge aclk) begin
    if (m_axi_awvalid && m_axi_awready) begin aw_cnt <= aw_cnt + 1; aw_seen <= m_axi_awaddr; end
    if (m_axi_wvalid && m_axi_wready) w_seen <= m_axi_wdata;
    if (wr_ack) wr_ack_cnt <= wr_ack_cnt + 1;
    if (rd_ack) rd_ack_cnt <= rd_ack_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int lat, wlat, rlat, aw0, wa0, ra0;
    logic gw, gr, cap_err;
    logic [31:0] cap_data;
    wr_addr = '0; rd_addr = '0; wr_req = 0; rd_req = 0; wr_be = '0; wr_data = '0;
    m_axi_awready = 1; m_axi_wready = 1; m_axi_arready = 1;
    bresp_cfg = 2'b00; rresp_cfg = 2'b00; rdata_cfg = '0; b_hold = 0; rwait_cfg = 0;
    areset = 1;
    repeat (3) @(negedge aclk);
    chk("rst_wr_busy", wr_busy, 0);
    chk("rst_rd_busy", rd_busy, 0);
    chk("rst_awvalid", m_axi_awvalid, 0);
    chk("rst_wvalid", m_axi_wvalid, 0);
    chk("rst_bready", m_axi_bready, 0);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_rready", m_axi_rready, 0);
    chk("rst_acks", {wr_ack, wr_err, rd_ack, rd_err}, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_awaddr", m_axi_awaddr, 0);
    areset = 0;
    @(negedge aclk);

    // Basic write, zero-wait slave
    wr_addr = 10'h005; wr_data = 32'hDEADBEEF; wr_be = 4'hF; wr_req = 1;
    @(negedge aclk); wr_req = 0; lat = 1;
    chk("w1_awvalid", m_axi_awvalid, 1);
    chk("w1_wvalid", m_axi_wvalid, 1);
    chk("w1_awaddr", m_axi_awaddr, 32'h014);
    chk("w1_wdata", m_axi_wdata, 32'hDEADBEEF);
    chk("w1_wstrb", m_axi_wstrb, 4'hF);
    chk("w1_awprot", m_axi_awprot, 0);
    chk("w1_busy", wr_busy, 1);
    while (!wr_ack && lat < 40) begin @(negedge aclk); lat++; end
    chk("w1_lat", lat, 3);
    chk("w1_err", wr_err, 0);
    chk("w1_busy_ack", wr_busy, 0);
    @(negedge aclk);
    chk("w1_ack_pulse", wr_ack, 0);

    // awready held off 4 cycles, SLVERR response
    m_axi_awready = 0; bresp_cfg = 2'b10; wa0 = wr_ack_cnt;
    wr_addr = 10'h0A3; wr_data = 32'hCAFEF00D; wr_be = 4'h5; wr_req = 1;
    @(negedge aclk); wr_req = 0;
    chk("w2_both_valid", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
    @(negedge aclk);
    chk("w2_wvalid_drop", m_axi_wvalid, 0);
    chk("w2_awvalid_hold", m_axi_awvalid, 1);
    repeat (2) begin
      @(negedge aclk);
      chk("w2_awvalid_wait", m_axi_awvalid, 1);
      chk("w2_awaddr_stable", m_axi_awaddr, 32'h28C);
    end
    m_axi_awready = 1; lat = 0;
    while (!wr_ack && lat < 40) begin @(negedge aclk); lat++; end
    chk("w2_done", wr_ack, 1);
    chk("w2_err", wr_err, 1);
    chk("w2_wdata_seen", w_seen, 32'hCAFEF00D);
    repeat (4) @(negedge aclk);
    chk("w2_one_ack", wr_ack_cnt - wa0, 1);
    chk("w2_err_idle", wr_err, 0);

    // Read with two wait cycles on R
    rwait_cfg = 2; rdata_cfg = 32'h12345678; rresp_cfg = 2'b00; ra0 = rd_ack_cnt;
    rd_addr = 10'h3FF; rd_req = 1;
    @(negedge aclk); rd_req = 0; lat = 1;
    chk("r1_arvalid", m_axi_arvalid, 1);
    chk("r1_araddr", m_axi_araddr, 32'hFFC);
    chk("r1_arprot", m_axi_arprot, 0);
    chk("r1_busy", rd_busy, 1);
    while (!rd_ack && lat < 40) begin @(negedge aclk); lat++; end
    chk("r1_lat", lat, 5);
    chk("r1_data", rd_data, 32'h12345678);
    chk("r1_err", rd_err, 0);
    rdata_cfg = 32'h0;
    repeat (4) @(negedge aclk);
    chk("r1_one_ack", rd_ack_cnt - ra0, 1);
    chk("r1_data_hold", rd_data, 32'h12345678);

    // Concurrent write + read, second wr_req while busy must be ignored
    rwait_cfg = 0; bresp_cfg = 2'b00; rdata_cfg = 32'hA5A55A5A; rresp_cfg = 2'b10;
    aw0 = aw_cnt; wa0 = wr_ack_cnt; ra0 = rd_ack_cnt;
    wr_addr = 10'h011; wr_data = 32'h11112222; wr_be = 4'h3; wr_req = 1;
    rd_addr = 10'h002; rd_req = 1;
    @(negedge aclk);
    rd_req = 0; wr_addr = 10'h3FE; wr_data = 32'h00000099;
    chk("c_busy", {wr_busy, rd_busy}, 2'b11);
    @(negedge aclk); wr_req = 0;
    gw = 0; gr = 0; lat = 0; cap_data = '0; cap_err = 0;
    while ((!gw || !gr) && lat < 40) begin
      @(negedge aclk); lat++;
      if (wr_ack) gw = 1;
      if (rd_ack) begin gr = 1; cap_data = rd_data; cap_err = rd_err; end
    end
    repeat (4) @(negedge aclk);
    chk("c_aw_count", aw_cnt - aw0, 1);
    chk("c_wr_acks", wr_ack_cnt - wa0, 1);
    chk("c_rd_acks", rd_ack_cnt - ra0, 1);
    chk("c_awaddr", aw_seen, 32'h044);
    chk("c_wdata", w_seen, 32'h11112222);
    chk("c_rd_data", cap_data, 32'hA5A55A5A);
    chk("c_rd_err", cap_err, 1);

    // Reset while waiting in W_RESP and R_ADDR
    b_hold = 1; m_axi_arready = 0; rresp_cfg = 2'b00;
    wa0 = wr_ack_cnt; ra0 = rd_ack_cnt;
    wr_addr = 10'h020; wr_data = 32'h77777777; wr_req = 1;
    rd_addr = 10'h030; rd_req = 1;
    @(negedge aclk); wr_req = 0; rd_req = 0;
    @(negedge aclk);
    chk("x_in_resp", m_axi_bready, 1);
    chk("x_in_addr", m_axi_arvalid, 1);
    #2 areset = 1;
    #1;
    chk("x_bready", m_axi_bready, 0);
    chk("x_arvalid", m_axi_arvalid, 0);
    chk("x_busy", {wr_busy, rd_busy}, 0);
    chk("x_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_rready}, 0);
    chk("x_rd_data", rd_data, 0);
    chk("x_wdata", m_axi_wdata, 0);
    repeat (2) @(negedge aclk);
    areset = 0; b_hold = 0; m_axi_arready = 1; rdata_cfg = 32'h0BADF00D;
    @(negedge aclk);
    chk("x_no_ack", {wr_ack_cnt - wa0, rd_ack_cnt - ra0}, 0);
    wr_addr = 10'h040; wr_data = 32'h55AA55AA; wr_req = 1;
    rd_addr = 10'h041; rd_req = 1;
    gw = 0; gr = 0; lat = 0; wlat = 99; rlat = 99;
    while ((!gw || !gr) && lat < 40) begin
      @(negedge aclk); lat++;
      if (lat == 1) begin wr_req = 0; rd_req = 0; end
      if (wr_ack && !gw) begin gw = 1; wlat = lat; end
      if (rd_ack && !gr) begin gr = 1; rlat = lat; cap_data = rd_data; end
    end
    chk("x_wr_lat", wlat, 3);
    chk("x_rd_lat", rlat, 3);
    chk("x_rd_data2", cap_data, 32'h0BADF00D);
    chk("x_awaddr2", aw_seen, 32'h100);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
